imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader_byte_packer.sv | 36 +++
 rtl/imem_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_loader.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_BYTES      = 2;
    localparam int unsigned LenW           = 8 * LEN_BYTES;
    localparam int unsigned LaneW          = $clog2(BYTES_PER_WORD);

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StLenLo = 3'd1;
    localparam state_t StLenHi = 3'd2;
    localparam state_t StData  = 3'd3;
    localparam state_t StWrite = 3'd4;
    localparam state_t StDone  = 3'd5;
    localparam state_t StErr   = 3'd6;

    // Full-width length check: no truncation to the address width.
    function automatic logic len_legal(input logic [LenW-1:0] n, input int unsigned max_words);
        return (n != '0) && (32'(n) <= max_words);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-RAM write port and status lines of the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    // Byte source / system side.
    modport master (
        output start, in_valid, in_byte,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

    // Loader side.
    modport slave (
        input  start, in_valid, in_byte,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian assembly of stream bytes into one instruction word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        load_i,
    input  logic [LaneW-1:0]            lane_i,
    input  logic [7:0]                  byte_i,
    // Assembly including the byte being loaded this cycle, so the caller can
    // capture a complete word on the edge that accepts its last byte.
    output logic [8*BYTES_PER_WORD-1:0] word_o
);

    logic [8*BYTES_PER_WORD-1:0] word_q, word_d;

    // Overlay the accepted byte onto its lane.
    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d[{lane_i, 3'b000} +: 8] = byte_i;
        end
    end

    // Assembly register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_d;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction RAM and holds the CPU
// in reset until a complete program has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_WORDS     = 1024,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    imem_loader_if.slave bus
);

    state_t              state_q, state_d;
    logic [LenW-1:0]     n_q, n_d;
    logic [ADDR_W:0]     word_idx_q, word_idx_d;
    logic [LaneW-1:0]    byte_idx_q, byte_idx_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                cpu_hold_q, cpu_hold_d;

    logic                        accept;
    logic                        pack_load;
    logic [8*BYTES_PER_WORD-1:0] pack_word;
    logic [LenW-1:0]             len_full;
    logic                        len_ok;
    logic                        last_byte;
    logic                        last_word;
    logic                        restart;

    assign accept    = bus.in_valid & in_ready_q;
    assign pack_load = accept & (state_q == StData);
    assign len_full  = {bus.in_byte, n_q[7:0]};
    assign len_ok    = len_legal(len_full, MAX_WORDS);
    assign last_byte = (byte_idx_q == LaneW'(BYTES_PER_WORD - 1));
    assign last_word = (LenW'(word_idx_q) == (n_q - LenW'(1)));
    assign restart   = bus.start &
                       ((state_q == StIdle) | (state_q == StDone) | (state_q == StErr));

    imem_loader_byte_packer u_packer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (pack_load),
        .lane_i (byte_idx_q),
        .byte_i (bus.in_byte),
        .word_o (pack_word)
    );

    // Next-state logic for the load sequencer and its registered outputs.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        error_d    = error_q;
        cpu_hold_d = cpu_hold_q;

        if (restart) begin
            state_d    = StLenLo;
            word_idx_d = '0;
            byte_idx_d = '0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            cpu_hold_d = 1'b1;
        end else begin
            case (state_q)
                StLenLo: begin
                    if (accept) begin
                        n_d[7:0] = bus.in_byte;
                        state_d  = StLenHi;
                    end
                end
                StLenHi: begin
                    if (accept) begin
                        n_d     = len_full;
                        state_d = len_ok ? StData : StErr;
                        error_d = ~len_ok;
                    end
                end
                StData: begin
                    if (accept) begin
                        byte_idx_d = byte_idx_q + LaneW'(1);
                        if (last_byte) begin
                            state_d   = StWrite;
                            wr_en_d   = 1'b1;
                            wr_addr_d = word_idx_q[ADDR_W-1:0];
                            wr_data_d = DATA_W'(pack_word);
                        end
                    end
                end
                StWrite: begin
                    if (last_word) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                        state_d    = StData;
                    end
                end
                StIdle, StDone, StErr: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        // Ready is decided from the upcoming state only, never from In_Valid.
        in_ready_d = (state_d == StLenLo) | (state_d == StLenHi) | (state_d == StData);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= HOLD_AT_RESET;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame table plus hand-written corner cases.
module tb_imem_loader;

    logic clk;
    logic rst_n;

    imem_loader_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    imem_loader #(
        .ADDR_W        (10),
        .DATA_W        (32),
        .MAX_WORDS     (1024),
        .HOLD_AT_RESET (1'b1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t wq[$];
    int  dbl_cnt  = 0;
    int  rdy_viol = 0;
    bit  prev_wr  = 1'b0;
    bit  session  = 1'b0;

    // Write capture and protocol watch, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) wq.push_back({bus.wr_addr, bus.wr_data});
        if (bus.wr_en === 1'b1 && prev_wr) dbl_cnt <= dbl_cnt + 1;
        prev_wr <= (bus.wr_en === 1'b1);
        if (session && (bus.in_ready !== ~(bus.wr_en | bus.done | bus.error)))
            rdy_viol <= rdy_viol + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else passed++;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Present one byte and hold it until accepted (bounded).
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int w = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("byte_accept", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    typedef struct {
        logic [79:0] frame;
        int          nbytes;
        bit          gapped;
        int          exp_words;
        logic [31:0] w0;
        logic [31:0] wlast;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] full_exp [1024];

    initial begin
        logic [7:0]  b;
        logic [31:0] w;
        int          n0;
        int          bad_addr;
        int          bad_data;
        int          rdy_seen;

        vecs[0] = '{frame: 80'h01_00_00_6F_00_10_04_93_00_02, nbytes: 10, gapped: 1'b0,
                    exp_words: 2, w0: 32'h0010_0493, wlast: 32'h0100_006F,
                    exp_done: 1'b1, exp_err: 1'b0};
        vecs[1] = '{frame: 80'h01_00_00_6F_00_10_04_93_00_02, nbytes: 10, gapped: 1'b1,
                    exp_words: 2, w0: 32'h0010_0493, wlast: 32'h0100_006F,
                    exp_done: 1'b1, exp_err: 1'b0};
        vecs[2] = '{frame: 80'h0000, nbytes: 2, gapped: 1'b0, exp_words: 0, w0: 32'h0,
                    wlast: 32'h0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[3] = '{frame: 80'h0401, nbytes: 2, gapped: 1'b0, exp_words: 0, w0: 32'h0,
                    wlast: 32'h0, exp_done: 1'b0, exp_err: 1'b1};
        vecs[4] = '{frame: 80'h12_34_56_78_00_01, nbytes: 6, gapped: 1'b1, exp_words: 1,
                    w0: 32'h1234_5678, wlast: 32'h1234_5678, exp_done: 1'b1, exp_err: 1'b0};
        vecs[5] = '{frame: 80'hFFFF, nbytes: 2, gapped: 1'b0, exp_words: 0, w0: 32'h0,
                    wlast: 32'h0, exp_done: 1'b0, exp_err: 1'b1};

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;

        // Asynchronous reset between clock edges.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_wr_en",    32'(bus.wr_en),    32'd0);
        check("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
        check("rst_wr_data",  bus.wr_data,       32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_error",    32'(bus.error),    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd0);

        // Frame table; vector 4 also covers recovery after the N=1025 error.
        for (int i = 0; i < 6; i++) begin
            wq.delete();
            dbl_cnt  = 0;
            rdy_viol = 0;
            pulse_start();
            session = 1'b1;
            for (int k = 0; k < vecs[i].nbytes; k++) begin
                b = vecs[i].frame[8*k +: 8];
                send_byte(b, vecs[i].gapped);
            end
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_nwrites", i), 32'(wq.size()), 32'(vecs[i].exp_words));
            if (vecs[i].exp_words >= 1 && wq.size() >= 1) begin
                check($sformatf("v%0d_addr0", i), 32'(wq[0].addr), 32'd0);
                check($sformatf("v%0d_data0", i), wq[0].data, vecs[i].w0);
            end
            if (vecs[i].exp_words >= 2 && wq.size() >= 2) begin
                check($sformatf("v%0d_addr1", i), 32'(wq[1].addr), 32'd1);
                check($sformatf("v%0d_data1", i), wq[1].data, vecs[i].wlast);
            end
            if (vecs[i].exp_words >= 1) begin
                check($sformatf("v%0d_hold_addr", i), 32'(bus.wr_addr),
                      32'(vecs[i].exp_words - 1));
                check($sformatf("v%0d_hold_data", i), bus.wr_data, vecs[i].wlast);
            end
            check($sformatf("v%0d_done", i),     32'(bus.done),     32'(vecs[i].exp_done));
            check($sformatf("v%0d_error", i),    32'(bus.error),    32'(vecs[i].exp_err));
            check($sformatf("v%0d_cpu_hold", i), 32'(bus.cpu_hold), 32'(!vecs[i].exp_done));
            check($sformatf("v%0d_ready_rule", i), 32'(rdy_viol), 32'd0);
            check($sformatf("v%0d_single_wr", i),  32'(dbl_cnt),  32'd0);
            session = 1'b0;
        end

        // Start pulsed while in DATA must be ignored.
        wq.delete();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        pulse_start();
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        repeat (4) @(negedge clk);
        check("mid_start_nwrites", 32'(wq.size()), 32'd1);
        if (wq.size() >= 1) check("mid_start_data", wq[0].data, 32'hDDCC_BBAA);
        check("mid_start_done", 32'(bus.done), 32'd1);

        // Largest program: 1024 words, addresses must run 0..1023 without wrap.
        wq.delete();
        dbl_cnt = 0;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            full_exp[i] = w;
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
        end
        repeat (4) @(negedge clk);
        check("full_nwrites", 32'(wq.size()), 32'd1024);
        bad_addr = 0;
        bad_data = 0;
        for (int i = 0; i < wq.size() && i < 1024; i++) begin
            if (32'(wq[i].addr) != 32'(i)) bad_addr++;
            if (wq[i].data !== full_exp[i]) bad_data++;
        end
        check("full_addr_order", 32'(bad_addr), 32'd0);
        check("full_data",       32'(bad_data), 32'd0);
        check("full_done",       32'(bus.done), 32'd1);
        check("full_single_wr",  32'(dbl_cnt),  32'd0);

        // Reset mid-load: outputs clear at once and nothing more is written.
        wq.delete();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(8'h11 * 8'(k + 1), 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        n0 = wq.size();
        check("rl_first_write", 32'(n0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rl_in_ready", 32'(bus.in_ready), 32'd0);
        check("rl_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("rl_wr_addr",  32'(bus.wr_addr),  32'd0);
        check("rl_wr_data",  bus.wr_data,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h77;
        rdy_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0) rdy_seen++;
        end
        bus.in_valid = 1'b0;
        check("rl_idle_ready", 32'(rdy_seen),   32'd0);
        check("rl_no_writes",  32'(wq.size()),  32'(n0));
        check("rl_done",       32'(bus.done),   32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
